// File: rtl/alu_arb.sv
// alu_arb: two-port round-robin arbiter that sequences one operation at a time onto the shared ALU.
// The winner's operands are held on the ALU for LAT cycles, then Y is captured and a done pulse issued.
module alu_arb #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [4:0] s0_i,
  input  logic [4:0] s1_i,
  input  logic       cin0_i,
  input  logic       cin1_i,
  input  logic [7:0] a0_i,
  input  logic [7:0] b0_i,
  input  logic [7:0] a1_i,
  input  logic [7:0] b1_i,
  output logic       done0_o,
  output logic       done1_o,
  output logic [7:0] y_o,
  output logic       busy_o,
  output logic [4:0] alu_s_o,
  output logic       alu_cin_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_y_i
);

  // state | meaning
  // IDLE  | arbitrating; ALU inputs driven to zero
  // EXEC  | operands held on ALU, settle counter running
  // DONE  | result captured, done pulse for the granted requester
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       last_gnt_q;
  logic       gnt_id_q;
  logic [4:0] op_s_q;
  logic       op_cin_q;
  logic [7:0] op_a_q;
  logic [7:0] op_b_q;
  logic [7:0] y_q;
  logic       done0_q;
  logic       done1_q;
  logic       busy_q;

  logic       any_req;
  logic       gnt_d;

  assign any_req = req0_i | req1_i;

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_d = req1_i;
    if (req0_i && req1_i) begin
      gnt_d = ~last_gnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      op_s_q     <= 5'd0;
      op_cin_q   <= 1'b0;
      op_a_q     <= 8'd0;
      op_b_q     <= 8'd0;
      y_q        <= 8'd0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_id_q   <= gnt_d;
            last_gnt_q <= gnt_d;
            op_s_q     <= gnt_d ? s1_i   : s0_i;
            op_cin_q   <= gnt_d ? cin1_i : cin0_i;
            op_a_q     <= gnt_d ? a1_i   : a0_i;
            op_b_q     <= gnt_d ? b1_i   : b0_i;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            y_q     <= alu_y_i;
            done0_q <= ~gnt_id_q;
            done1_q <= gnt_id_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Clearing the operand regs here is what parks the ALU inputs at zero in IDLE.
          done0_q  <= 1'b0;
          done1_q  <= 1'b0;
          busy_q   <= 1'b0;
          op_s_q   <= 5'd0;
          op_cin_q <= 1'b0;
          op_a_q   <= 8'd0;
          op_b_q   <= 8'd0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done0_o   = done0_q;
  assign done1_o   = done1_q;
  assign y_o       = y_q;
  assign busy_o    = busy_q;
  assign alu_s_o   = op_s_q;
  assign alu_cin_o = op_cin_q;
  assign alu_a_o   = op_a_q;
  assign alu_b_o   = op_b_q;

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-port round-robin arbiter and sequencer for the shared 8-bit ALU (5-bit opcode S, carry-in Cin, operands A/B, result Y). It sits between two requesting units and the single combinational `alu` instance, which is instantiated by the parent and wired to the `alu_*` ports. The block latches the granted requester's opcode and operands, holds them stable on the ALU for a programmable settle time, and captures Y. It returns the result to the granted requester with a one-cycle done pulse.

## Interface
- `LAT`, default 1: ALU settle cycles in EXEC before Y is captured. Legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: operation request from requester 0 / 1. Must be held high until that requester's done pulse.
- `s0` / `s1` in 5: requester opcode, same encoding as ALU S.
- `cin0` / `cin1` in 1: requester carry-in.
- `a0, b0` / `a1, b1` in 8 each: requester operands.
- `done0` / `done1` out 1: one-cycle pulse; `y` is valid for that requester.
- `y` out 8: captured ALU result, shared by both requesters.
- `busy` out 1: high whenever state ≠ IDLE.
- `alu_s` out 5, `alu_cin` out 1, `alu_a` out 8, `alu_b` out 8: drive the shared ALU.
- `alu_y` in 8: ALU result.

## Operation
- **States:** IDLE, EXEC, DONE.
- **IDLE**
  - If neither req is high: stay in IDLE.
  - If exactly one req is high: grant it.
  - If both are high: grant the requester opposite `last_gnt`.
  - On grant: latch s/cin/a/b of the winner into operand regs, set `gnt_id`, set `last_gnt`←winner, set cnt←LAT-1, go to EXEC.
- **EXEC**
  - `alu_*` are driven from the operand regs. Requester inputs are ignored, so changes after grant have no effect.
  - If cnt≠0: cnt←cnt-1.
  - If cnt=0: y←alu_y, done[gnt_id]←1, go to DONE.
- **DONE**
  - `done[gnt_id]` is high for exactly this cycle; `alu_*` still show the operand regs.
  - Next edge: done←0, go to IDLE.
  - A requester drops or re-asserts req at that same edge. A re-asserted req is arbitrated normally in IDLE.
- **ALU drive in IDLE:** `alu_s`, `alu_cin`, `alu_a`, `alu_b` are 0.
- **Result width:** `y` holds its value until the next capture. No arithmetic in this block: Y is passed through as 8 bits.
- **Reset (any state, including mid-EXEC):**
  - State←IDLE; `done0`, `done1`, `busy` = 0; `y`=0; operand regs and `alu_*`=0; cnt=0.
  - `last_gnt`←1, so requester 0 wins the first contended grant.
  - An in-flight op is discarded and no done pulse is emitted. Requesters re-issue after reset.
- **Protocol violations:** req dropped before done is a violation. The arbiter still completes the op and pulses done.

## Timing
- Req sampled high at IDLE edge E0: EXEC from E0; capture at edge E0+LAT; done high in cycle E0+LAT..E0+LAT+1; IDLE at E0+LAT+1.
- Request-to-done latency: LAT cycles after the granting edge.
- Back-to-back throughput, same or alternating requester: one op per LAT+2 cycles.
- Both reqs held continuously: grants strictly alternate 0,1,0,1… No starvation; worst-case wait is one op.
- `busy` is registered with the state: high from E0 until the edge returning to IDLE.

## Test plan
Bench-only ALU stub: `alu_y = alu_a ^ alu_b ^ {8{alu_cin}}`.

1. **Reset values:** hold rst for 2 cycles with req0=req1=1 → `busy`=0, `done0`=`done1`=0, `y`=00000000, `alu_*`=0. Release rst → first grant goes to requester 0.
2. **Single op, LAT=1:** req0=1, a0=10101010, b0=01010101, cin0=0, s0=00001 → `alu_s`=00001 in EXEC. `done0` pulses exactly 1 cycle after the grant edge with `y`=11111111. `done1` stays 0.
3. **Operand isolation, LAT=3:** req1, a1=11110000, b1=00000000, cin1=1. Change a1 to 00000000 the cycle after grant → `y`=00001111 with `done1` 3 cycles after grant. `alu_a` stays 11110000 throughout EXEC.
4. **Contention:** req0 and req1 held high for 4 ops, a0=00011000, a1=10100000, b=0, cin=0 → done order 0,1,0,1. `y` alternates 00011000 / 10100000. Ops are spaced LAT+2 cycles apart.
5. **Reset mid-EXEC, LAT=4:** assert rst 2 cycles into EXEC → no done pulse, `busy`=0 and `y`=0 the next cycle. Re-request with a0=00000001, b0=0 → `y`=00000001.
6. **Re-request in DONE:** req0 kept high through its done with new a0=00000011, b0=0 → second grant on the first IDLE edge. Second `done0` LAT+2 cycles after the first, `y`=00000011.
